// File: rtl/poly_wave_synth.sv
// poly_wave_synth
//   Polyphonic, time-multiplexed wave synthesiser. VOICES phase accumulators
//   are serviced one per cycle. Each voice produces a square, saw or triangle
//   sample. The voices are mixed into one signed sample, and that sample is
//   pushed into the codec write FIFO.
//
//   Sample cycle: IDLE -> ACCUM (VOICES cycles, one voice each) -> OUT (push).
//
// Ports
//   clock            system clock
//   reset_n          synchronous, active-low reset
//   key_on           per-voice gate (bit v = voice v held)
//   note             per-voice note index, 4 bits per voice; 0..11 = C..B, 12..15 silent
//   octave           shared octave shift 0..7
//   wave             shared waveform: 00 square, 01 saw, 10 triangle, 11 silent
//   write_ready      codec FIFO can accept a sample
//   write            one-cycle push strobe to the codec
//   writedata_left   mixed sample, two's complement
//   writedata_right  copy of writedata_left (mono)
//   active           per-voice sounding flag
//
// Configuration macro
//   POLY_SYNTH_ZC_EN  when defined, a released voice keeps sounding until its
//                     phase wraps, so the note ends on a zero crossing.
//                     When undefined, a released voice stops at once.

module poly_wave_synth #(
    parameter int VOICES   = 4,
    parameter int SAMPLE_W = 24
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [VOICES-1:0]     key_on,
    input  logic [4*VOICES-1:0]   note,
    input  logic [2:0]            octave,
    input  logic [1:0]            wave,
    input  logic                  write_ready,
    output logic                  write,
    output logic [SAMPLE_W-1:0]   writedata_left,
    output logic [SAMPLE_W-1:0]   writedata_right,
    output logic [VOICES-1:0]     active
);

    localparam int LOGV  = $clog2(VOICES);
    localparam int MIX_W = 8 + LOGV;
    localparam int SHIFT = SAMPLE_W - MIX_W;
    localparam int IDX_W = (VOICES > 1) ? LOGV : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOut
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           vidx_q, vidx_d;
    logic signed [MIX_W-1:0]    acc_q, acc_d;
    logic [23:0]                phase_q [VOICES];
    logic [VOICES-1:0]          active_q;
    logic [SAMPLE_W-1:0]        writedata_q;

    // Currently serviced voice
    logic                       cur_key;
    logic [3:0]                 cur_note;
    logic [23:0]                cur_phase;
    logic                       cur_active;

    logic [13:0]                base;
    logic [23:0]                inc;
    logic [24:0]                phase_sum;
    logic [7:0]                 p;
    logic [6:0]                 tri_t;
    logic signed [7:0]          wav_val;
    logic signed [7:0]          contrib;
    logic [23:0]                phase_nxt;
    logic                       active_nxt;

    logic                       upd_en;
    logic                       push;
    logic signed [SAMPLE_W-1:0] mix_ext;
    logic [SAMPLE_W-1:0]        mix_sample;

    // Voice select: loop compare avoids out-of-range indexing when VOICES is
    // not a power of two.
    always_comb begin
        cur_key    = 1'b0;
        cur_note   = 4'd0;
        cur_phase  = 24'd0;
        cur_active = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            if (vidx_q == IDX_W'(v)) begin
                cur_key    = key_on[v];
                cur_note   = note[4*v +: 4];
                cur_phase  = phase_q[v];
                cur_active = active_q[v];
            end
        end
    end

    // Phase increments for C..B at 48 kHz on a 2^24 phase, octave 0
    always_comb begin
        case (cur_note)
            4'd0:    base = 14'd5715;
            4'd1:    base = 14'd6055;
            4'd2:    base = 14'd6415;
            4'd3:    base = 14'd6797;
            4'd4:    base = 14'd7201;
            4'd5:    base = 14'd7629;
            4'd6:    base = 14'd8083;
            4'd7:    base = 14'd8563;
            4'd8:    base = 14'd9072;
            4'd9:    base = 14'd9612;
            4'd10:   base = 14'd10183;
            4'd11:   base = 14'd10789;
            default: base = 14'd0;
        endcase
    end

    assign inc       = {10'd0, base} << octave;
    assign phase_sum = {1'b0, cur_phase} + {1'b0, inc};

    // Waveform from the pre-update phase. Subtracting 128 from an unsigned
    // byte is the same as flipping its MSB.
    assign p     = cur_phase[23:16];
    assign tri_t = p[7] ? ~p[6:0] : p[6:0];

    always_comb begin
        unique case (wave)
            2'b00:   wav_val = p[7] ? -8'sd127 : 8'sd127;
            2'b01:   wav_val = {~p[7], p[6:0]};
            2'b10:   wav_val = {~tri_t[6], tri_t[5:0], 1'b0};
            default: wav_val = 8'sd0;
        endcase
    end

    assign contrib = cur_active ? wav_val : 8'sd0;

    // Voice state update
    always_comb begin
        phase_nxt  = cur_phase;
        active_nxt = cur_active;
        if (cur_key) begin
            if (!cur_active) begin
                active_nxt = 1'b1;
                phase_nxt  = 24'd0;
            end else begin
                phase_nxt = phase_sum[23:0];
            end
        end else if (cur_active) begin
`ifdef POLY_SYNTH_ZC_EN
            // Keep sounding through release; stop on the wrap.
            if (phase_sum[24]) begin
                active_nxt = 1'b0;
                phase_nxt  = 24'd0;
            end else begin
                phase_nxt = phase_sum[23:0];
            end
`else
            active_nxt = 1'b0;
            phase_nxt  = 24'd0;
`endif
        end
    end

    // Sequencer
    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        acc_d   = acc_q;
        upd_en  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                vidx_d = '0;
                if (write_ready) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                upd_en = 1'b1;
                // Voice 0 restarts the sum so no stale partial survives.
                if (vidx_q == '0) begin
                    acc_d = MIX_W'(contrib);
                end else begin
                    acc_d = acc_q + MIX_W'(contrib);
                end
                if (vidx_q == LAST_IDX) begin
                    vidx_d  = '0;
                    state_d = StOut;
                end else begin
                    vidx_d = vidx_q + 1'b1;
                end
            end
            StOut: begin
                push = write_ready;
                if (write_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mix_ext    = SAMPLE_W'(acc_q);
    assign mix_sample = mix_ext <<< SHIFT;

    // Push suppressed during reset. Fresh data is presented with the strobe
    // and is held until the next push.
    assign write           = push & reset_n;
    assign writedata_left  = write ? mix_sample : writedata_q;
    assign writedata_right = writedata_left;
    assign active          = active_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            vidx_q      <= '0;
            acc_q       <= '0;
            active_q    <= '0;
            writedata_q <= '0;
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= 24'd0;
            end
        end else begin
            state_q <= state_d;
            vidx_q  <= vidx_d;
            acc_q   <= acc_d;
            if (push) begin
                writedata_q <= mix_sample;
            end
            for (int v = 0; v < VOICES; v++) begin
                if (upd_en && (vidx_q == IDX_W'(v))) begin
                    phase_q[v]  <= phase_nxt;
                    active_q[v] <= active_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_wave_synth.sv
// Testbench for poly_wave_synth.
// A behavioural model steps every voice once per pushed sample. The bench
// compares each push, the held data and the strobe behaviour against it.

module tb_poly_wave_synth;

    localparam int VOICES   = 4;
    localparam int SAMPLE_W = 24;
    localparam int LOGV     = $clog2(VOICES);
    localparam int SHIFT    = SAMPLE_W - 8 - LOGV;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [VOICES-1:0]     key_on = '0;
    logic [4*VOICES-1:0]   note = '0;
    logic [2:0]            octave = '0;
    logic [1:0]            wave = '0;
    logic                  write_ready = 1'b0;
    logic                  write;
    logic [SAMPLE_W-1:0]   writedata_left;
    logic [SAMPLE_W-1:0]   writedata_right;
    logic [VOICES-1:0]     active;

    poly_wave_synth #(
        .VOICES   (VOICES),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .key_on          (key_on),
        .note            (note),
        .octave          (octave),
        .wave            (wave),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .active          (active)
    );

    always #10 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    int base_tab [12] = '{5715, 6055, 6415, 6797, 7201, 7629,
                          8083, 8563, 9072, 9612, 10183, 10789};
    longint m_phase [VOICES];
    bit     m_active [VOICES];

    logic [SAMPLE_W-1:0] last_push;
    int                  since;
    bit                  first_push;

    function automatic int wav_of(input int pv, input int w);
        int t;
        case (w)
            0: return (pv >= 128) ? -127 : 127;
            1: return pv - 128;
            2: begin
                t = (pv >= 128) ? 255 - pv : pv;
                return 2 * t - 128;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_phase[v]  = 0;
            m_active[v] = 0;
        end
        last_push  = '0;
        first_push = 1'b1;
        since      = 0;
    endtask

    // One sample: sum the pre-update contributions, then advance every voice.
    task automatic model_step(output logic [SAMPLE_W-1:0] exp);
        int            sum;
        int            n;
        longint        inc;
        logic [31:0]   scaled;
        sum = 0;
        for (int v = 0; v < VOICES; v++) begin
            n   = int'((note >> (4 * v)) & 16'hF);
            inc = (n < 12) ? (longint'(base_tab[n]) << octave) : 0;
            if (m_active[v]) sum += wav_of(int'((m_phase[v] >> 16) & 255), int'(wave));
            if (key_on[v] && !m_active[v]) begin
                m_active[v] = 1;
                m_phase[v]  = 0;
            end else if (key_on[v] && m_active[v]) begin
                m_phase[v] = (m_phase[v] + inc) % (64'd1 << 24);
            end else if (!key_on[v] && m_active[v]) begin
`ifdef POLY_SYNTH_ZC_EN
                if (m_phase[v] + inc >= (64'd1 << 24)) begin
                    m_active[v] = 0;
                    m_phase[v]  = 0;
                end else begin
                    m_phase[v] = m_phase[v] + inc;
                end
`else
                m_active[v] = 0;
                m_phase[v]  = 0;
`endif
            end
        end
        scaled = 32'(sum * (1 << SHIFT));
        exp = scaled[SAMPLE_W-1:0];
    endtask

    // Run until one push. mode 0: random write_ready, 1: always ready,
    // 2: ready for two cycles, then low for 'stall' cycles.
    task automatic do_sample(input int mode, input int stall, output logic [SAMPLE_W-1:0] got);
        logic [SAMPLE_W-1:0] exp;
        bit                  seen;
        int                  cyc;
        model_step(exp);
        seen = 0;
        cyc  = 0;
        got  = '0;
        while (!seen && cyc < 200) begin
            @(negedge clock);
            case (mode)
                0:       write_ready = ($urandom_range(0, 3) != 0);
                2:       write_ready = (cyc < 2) || (cyc >= 2 + stall);
                default: write_ready = 1'b1;
            endcase
            #1;
            since++;
            if (write) begin
                check("write_when_ready", {31'd0, write_ready}, 32'd1);
                if (!first_push) check("period", {31'd0, since >= VOICES + 2}, 32'd1);
                check("sample", writedata_left, exp);
                check("mono", writedata_right, writedata_left);
                last_push  = writedata_left;
                got        = writedata_left;
                since      = 0;
                first_push = 1'b0;
                seen       = 1;
            end else begin
                check("hold", writedata_left, last_push);
            end
            cyc++;
        end
        if (!seen) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    logic [SAMPLE_W-1:0] got;
    int                  nz;

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_left", writedata_left, 32'd0);
        check("rst_right", writedata_right, 32'd0);
        check("rst_active", active, 32'd0);
        reset_n = 1'b1;

        // No keys: silence
        for (int i = 0; i < 4; i++) begin
            do_sample(1, 0, got);
            check("idle_zero", got, 32'd0);
            check("idle_active", active, 32'd0);
        end

        // Voice 0, note A, octave 4, square
        note   = 16'h0009;
        octave = 3'd4;
        wave   = 2'b00;
        key_on = 4'b0001;
        do_sample(1, 0, got);
        check("sq_first", got, 32'd0);
        check("sq_active", active, 32'd1);
        do_sample(1, 0, got);
        check("sq_second", got, 32'h1FC000);
        for (int i = 0; i < 54; i++) do_sample(0, 0, got);
        check("sq_pre_flip", got, 32'h1FC000);
        do_sample(0, 0, got);
        check("sq_flip", got, 32'hE04000);

        // Codec stalls in OUT for 20+ cycles
        do_sample(2, 24, got);
        do_sample(2, 30, got);

        // Saw
        do_reset();
        wave   = 2'b01;
        key_on = 4'b0001;
        note   = 16'h0009;
        do_sample(1, 0, got);
        do_sample(1, 0, got);
        check("saw_second", got, 32'hE00000);

        // All four voices square
        do_reset();
        wave   = 2'b00;
        note   = 16'h9999;
        key_on = 4'hF;
        do_sample(1, 0, got);
        do_sample(1, 0, got);
        check("quad_second", got, 32'h7F0000);

        // Release mid-note
        do_reset();
        note   = 16'h0009;
        key_on = 4'b0001;
        for (int i = 0; i < 10; i++) do_sample(0, 0, got);
        key_on = 4'b0000;
        nz = 0;
        for (int i = 0; i < 115; i++) begin
            do_sample(0, 0, got);
            if (got != '0) nz++;
        end
`ifdef POLY_SYNTH_ZC_EN
        check("rel_count", {31'd0, nz >= 2 && nz <= 111}, 32'd1);
`else
        check("rel_count", nz, 32'd1);
`endif
        check("rel_active", active, 32'd0);

        // Random stimulus
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) key_on = VOICES'($urandom);
            if ($urandom_range(0, 3) == 0) note = 16'($urandom);
            if ($urandom_range(0, 7) == 0) octave = 3'($urandom);
            if ($urandom_range(0, 7) == 0) wave = 2'($urandom);
            do_sample(0, 0, got);
        end

        // Reset during voice 2 of ACCUM
        key_on = 4'hF;
        note   = 16'h4321;
        wave   = 2'b10;
        for (int i = 0; i < 3; i++) do_sample(1, 0, got);
        write_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            #1;
            check("pre_rst_nowrite", {31'd0, write}, 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_acc_write", {31'd0, write}, 32'd0);
        @(negedge clock);
        #1;
        check("rst_acc_write2", {31'd0, write}, 32'd0);
        check("rst_acc_left", writedata_left, 32'd0);
        check("rst_acc_right", writedata_right, 32'd0);
        check("rst_acc_active", active, 32'd0);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) do_sample(0, 0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_wave_synth.md
# poly_wave_synth

Polyphonic, time-multiplexed wave synthesiser that replaces the single-voice square/saw counter generator. It holds VOICES phase accumulators, generates square, saw or triangle samples per voice, and mixes them into one signed sample. Each sample is pushed into the audio codec write FIFO through the codec's write/write_ready handshake. It sits between key_interpreter (key_on/note inputs) and audio_codec (writedata_left/right, write).

## Interface
Parameters:
- VOICES, 4, number of voices; legal range 1..16.
- SAMPLE_W, 24, codec sample width; must be >= 8 + clog2(VOICES).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; synchronous, active-low.
- key_on  in  VOICES  per-voice gate; bit v high means voice v is held.
- note  in  4*VOICES  per-voice note index; bits [4v+3:4v] belong to voice v. Values 0..11 are C..B; 12..15 mean silent (increment 0).
- octave  in  3  shared octave shift, 0..7.
- wave  in  2  shared waveform: 00 square, 01 saw, 10 triangle, 11 silent (value 0).
- write_ready  in  1  codec FIFO can accept a sample.
- write  out  1  one-cycle push strobe to codec.
- writedata_left  out  SAMPLE_W  mixed sample, two's complement.
- writedata_right  out  SAMPLE_W  identical to writedata_left (mono).
- active  out  VOICES  per-voice sounding flag.

## Operation
- Each voice has a 24-bit phase register and an active flag.
- Phase increment is base[note] << octave. Base values for C..B at 48 kHz on a 2^24 phase: 5715, 6055, 6415, 6797, 7201, 7629, 8083, 8563, 9072, 9612, 10183, 10789.
- The waveform input is p = phase[23:16], treated as unsigned.
  - Square: p[7] ? -127 : +127.
  - Saw: p - 128.
  - Triangle: t = p[7] ? ~p[6:0] : p[6:0]; value = {t,0} - 128.
  - All waveform values are signed 8-bit.
- Per-voice contribution is active ? wav(phase) : 0. It is computed from the phase before that sample's update.
- Voice update, once per sample, in the voice's ACCUM cycle:
  - key_on=1, active=0: set active=1 and phase=0.
  - key_on=1, active=1: phase += inc, modulo 2^24.
  - key_on=0, active=1: release, behaviour set by the Configuration macro.
  - key_on=0, active=0: no change.
- Mix: sum all contributions at width 8+clog2(VOICES), sign-extend, then shift left by SAMPLE_W-8-clog2(VOICES). The sum cannot overflow and needs no saturation.
- FSM states:
  - IDLE: go to ACCUM when write_ready=1.
  - ACCUM: lasts VOICES cycles. The voice index runs 0..VOICES-1, one voice is processed and accumulated per cycle, and note, octave and wave are sampled in that voice's cycle. Go to OUT after voice VOICES-1.
  - OUT: write = write_ready. Load writedata in the cycle write is asserted. Return to IDLE when write_ready=1; otherwise stay in OUT with write=0.
- writedata holds its value between pushes.

## Timing
- Reset values: write=0, writedata_left=writedata_right=0, active=0, all phases 0, accumulator 0, FSM in IDLE.
- Minimum sample period is VOICES+2 cycles: IDLE, then VOICES ACCUM cycles, then OUT.
- write is asserted exactly once per sample and never while write_ready=0.
- If write_ready drops during ACCUM, ACCUM completes and OUT waits for write_ready.
- Reset mid-ACCUM or mid-OUT discards the partial sum, suppresses write, and clears all state in that cycle.
- key_on or note changes take effect at that voice's next ACCUM cycle; there is no mid-sample glitch.
- Pitch accuracy relies on the codec draining its FIFO at 48 kHz. The block refills whenever write_ready=1.

## Configuration
- POLY_SYNTH_ZC_EN defined: on release the voice keeps sounding and its phase keeps advancing. In the update cycle where phase + inc carries out of bit 23, set active=0 and phase=0. This avoids release clicks.
- POLY_SYNTH_ZC_EN undefined: on release, set active=0 and phase=0 in the same update. The releasing sample still contributes its pre-update value; later samples contribute 0.

## Test plan
- Reset, write_ready=1, no keys: every write carries 24'h000000 and active=0.
- Voice0 note=9, octave=4, square, key_on[0] rising: first push 0 with active[0]=1. Second push 24'h1FC000. Phase then advances 153792 per sample and the sign flips after 55 samples.
- Same setup with wave=01: second push 24'hE00000. All four voices square, key_on=4'hF: second push 24'h7F0000.
- write_ready held low for 20 cycles in OUT: write stays 0 and data is stable. write is a single one-cycle pulse when write_ready returns.
- key_on[0] drops mid-note:
  - Macro undefined: exactly one more nonzero push, then 0.
  - Macro defined: nonzero pushes continue until phase wrap (at most 110 samples), then active[0]=0.
- reset_n low during ACCUM of voice 2 (VOICES=4): no write, and all outputs are 0 on the next cycle.
